// File: rtl/mem_access_engine.sv
// Memory access stage: scalar/vector load-store over a W-item beat port.
// Unit stride issues W items per beat; any other stride issues one item per beat on lane 0.
module mem_access_engine #(
  parameter int I = 20,
  parameter int L = 8,
  parameter int A = 32,
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           op_type,
  input  logic           op_source,
  input  logic           write_enable,
  input  logic [A-1:0]   address,
  input  logic [A-1:0]   stride,
  input  logic [I*L-1:0] aluResultV,
  input  logic [I*L-1:0] rd2_vec,
  input  logic [L-1:0]   aluResultS,
  input  logic [L-1:0]   rd2_sca,
  output logic           mem_req,
  input  logic           mem_gnt,
  output logic           mem_we,
  output logic [A-1:0]   mem_addr,
  output logic [W*L-1:0] mem_wdata,
  output logic [W-1:0]   mem_wmask,
  input  logic           mem_rvalid,
  input  logic [W*L-1:0] mem_rdata,
  output logic           busy,
  output logic           done,
  output logic [L-1:0]   scalar_output,
  output logic [I*L-1:0] vector_output
);

  localparam int IL    = I * L;
  localparam int NBU   = (I + W - 1) / W;
  localparam int LASTN = I - (NBU - 1) * W;
  localparam int BW    = $clog2(I + 1);
  localparam logic [IL-1:0] LANE_ONES = IL'({L{1'b1}});

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RWAIT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            vec_q, we_q, unit_q;
  logic [A-1:0]    addr_q, stride_q;
  logic [IL-1:0]   sdata_q, buf_q, buf_d, vout_q;
  logic [L-1:0]    sout_q;
  logic [BW-1:0]   beat_q, nb_m1;
  logic            last_beat, adv, fin_load;
  logic [W-1:0]    mask;
  logic [W*L-1:0]  wdata_raw;
  logic [IL-1:0]   tmp;
  int              item_base, sh;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_REQ;
      S_REQ:   if (mem_gnt) begin
                 if (!we_q)          state_d = S_RWAIT;
                 else if (last_beat) state_d = S_DONE;
               end
      S_RWAIT: if (mem_rvalid) state_d = last_beat ? S_DONE : S_REQ;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req   = (state_q == S_REQ);
    mem_we    = mem_req & we_q;
    mem_addr  = addr_q;
    mem_wmask = mem_req ? mask : '0;
    mem_wdata = (mem_req && we_q) ? wdata_raw : '0;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
  end

  // Beat plan: lane k of the current beat carries item item_base+k.
  always_comb begin
    nb_m1 = '0;
    if (vec_q) nb_m1 = unit_q ? BW'(NBU - 1) : BW'(I - 1);
    last_beat = (beat_q == nb_m1);
    item_base = (vec_q && unit_q) ? int'(beat_q) * W : int'(beat_q);
    mask      = '0;
    wdata_raw = '0;
    buf_d     = buf_q;
    tmp       = '0;
    sh        = 0;
    for (int k = 0; k < W; k++) begin
      if (!vec_q || !unit_q) mask[k] = (k == 0);
      else                   mask[k] = !last_beat || (k < LASTN);
      if (mask[k] && (item_base + k) < I) begin
        sh  = (item_base + k) * L;
        tmp = sdata_q >> sh;
        wdata_raw[k*L +: L] = tmp[L-1:0];
        if (state_q == S_RWAIT && mem_rvalid)
          buf_d = (buf_d & ~(LANE_ONES << sh)) | (IL'(mem_rdata[k*L +: L]) << sh);
      end
    end
    adv = ((state_q == S_REQ) && mem_gnt && we_q && !last_beat) ||
          ((state_q == S_RWAIT) && mem_rvalid && !last_beat);
    fin_load = (state_q == S_RWAIT) && mem_rvalid && last_beat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vec_q    <= 1'b0;
      we_q     <= 1'b0;
      unit_q   <= 1'b0;
      addr_q   <= '0;
      stride_q <= '0;
      sdata_q  <= '0;
      buf_q    <= '0;
      vout_q   <= '0;
      sout_q   <= '0;
      beat_q   <= '0;
    end else begin
      buf_q <= buf_d;
      if (state_q == S_IDLE && start) begin
        vec_q    <= op_type;
        we_q     <= write_enable;
        unit_q   <= (stride == A'(1));
        addr_q   <= address;
        stride_q <= stride;
        beat_q   <= '0;
        if (op_type) sdata_q <= op_source ? aluResultV : rd2_vec;
        else         sdata_q <= IL'(op_source ? aluResultS : rd2_sca);
      end else if (adv) begin
        beat_q <= beat_q + BW'(1);
        addr_q <= addr_q + (unit_q ? A'(W) : stride_q);
      end
      // Results become visible together with the done pulse, never partially.
      if (fin_load) begin
        if (vec_q) vout_q <= buf_d;
        else       sout_q <= buf_d[L-1:0];
      end
    end
  end

  assign scalar_output = sout_q;
  assign vector_output = vout_q;

endmodule
